// File: rtl/random_pkg.sv
// Shared types and constants for the random slicer: FSM states, word width,
// and the slices-per-word helper.
package random_pkg;

  localparam int RANDOM_WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Number of slices carried by one FIFO word.
  function automatic int slice_count(input int slice_w);
    return RANDOM_WORD_W / slice_w;
  endfunction

endpackage

// File: rtl/random_threshold_cmp.sv
// Registered unsigned slice-vs-threshold comparator. It loads on the same edge
// that registers the slice, so decision lines up with rnd_valid.
module random_threshold_cmp #(
  parameter int SLICE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [SLICE_W-1:0] slice,
  input  logic [SLICE_W-1:0] threshold,
  output logic               decision
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     decision <= 1'b0;
    else if (load) decision <= (slice < threshold);
  end

endmodule

// File: rtl/random_slicer.sv
// Cuts 64-bit words from an upstream random FIFO into SLICE_W-bit slices, LSB first.
// Optional feature macro RANDOM_SLICER_COMPARE_EN adds threshold/decision.
module random_slicer
  import random_pkg::*;
#(
  parameter int SLICE_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [RANDOM_WORD_W-1:0] fifo_dout,
  input  logic                     fifo_valid,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic                     flush,
  input  logic                     req,
  output logic                     rnd_ready,
  output logic [SLICE_W-1:0]       rnd_out,
  output logic                     rnd_valid,
  output logic                     overrun
`ifdef RANDOM_SLICER_COMPARE_EN
  ,
  input  logic [SLICE_W-1:0]       threshold,
  output logic                     decision
`endif
);

  localparam int N     = slice_count(SLICE_W);
  localparam int CNT_W = $clog2(N + 1);

  state_t                   state;
  logic [RANDOM_WORD_W-1:0] buffer, buffer_nxt;
  logic [CNT_W-1:0]         slices_left, slices_nxt;
  logic                     accept;

  // rnd_ready mirrors slices_left != 0, so an accepted req always has data.
  assign accept = req && rnd_ready && !flush;

  // A load can only happen in WAIT, where slices_left is 0, so it never races an accept.
  always_comb begin
    slices_nxt = slices_left;
    buffer_nxt = buffer;
    if (flush) begin
      slices_nxt = '0;
    end else if (state == WAIT && fifo_valid) begin
      slices_nxt = CNT_W'(N);
      buffer_nxt = fifo_dout;
    end else if (accept) begin
      slices_nxt = slices_left - CNT_W'(1);
      buffer_nxt = buffer >> SLICE_W;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      buffer      <= '0;
      slices_left <= '0;
      rnd_ready   <= 1'b0;
      rnd_out     <= '0;
      rnd_valid   <= 1'b0;
      fifo_rd_en  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      buffer      <= buffer_nxt;
      slices_left <= slices_nxt;
      rnd_ready   <= (slices_nxt != '0);
      rnd_valid   <= accept;
      fifo_rd_en  <= 1'b0;
      if (accept) rnd_out <= buffer[SLICE_W-1:0];
      if (req && !rnd_ready && !flush) overrun <= 1'b1;

      // Flush abandons any outstanding read; its late response lands in IDLE and is dropped.
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (slices_left == '0 && !fifo_empty) begin
              state      <= FETCH;
              fifo_rd_en <= 1'b1;
            end
          end
          FETCH:   state <= WAIT;
          WAIT:    if (fifo_valid) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RANDOM_SLICER_COMPARE_EN
  random_threshold_cmp #(
    .SLICE_W (SLICE_W)
  ) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .slice     (buffer[SLICE_W-1:0]),
    .threshold (threshold),
    .decision  (decision)
  );
`endif

endmodule

// File: tb/tb_random_slicer.sv
// Directed bench for random_slicer (SLICE_W=16) with a small queue-backed FIFO.
// Comparator checks are active when RANDOM_SLICER_COMPARE_EN is defined.
module tb_random_slicer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] fifo_dout;
  logic        fifo_valid;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        flush;
  logic        req;
  logic        rnd_ready;
  logic [15:0] rnd_out;
  logic        rnd_valid;
  logic        overrun;
`ifdef RANDOM_SLICER_COMPARE_EN
  logic [15:0] threshold;
  logic        decision;
`endif

  random_slicer #(.SLICE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .req        (req),
    .rnd_ready  (rnd_ready),
    .rnd_out    (rnd_out),
    .rnd_valid  (rnd_valid),
    .overrun    (overrun)
`ifdef RANDOM_SLICER_COMPARE_EN
    ,
    .threshold  (threshold),
    .decision   (decision)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] q[$];
  logic        auto_fifo;
  logic        rd_pend;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the FIFO model answers a read acknowledge one cycle later.
  task automatic step();
    @(posedge clk);
    #1;
    if (auto_fifo) begin
      fifo_valid = 1'b0;
      if (rd_pend && q.size() > 0) begin
        fifo_dout  = q.pop_front();
        fifo_valid = 1'b1;
      end
      rd_pend    = fifo_rd_en;
      fifo_empty = (q.size() == 0);
    end
  endtask

  logic [15:0] exp_a [4];
  logic [15:0] exp_b [8];
  int          exp_vc [8];
  int          rd_cyc [4];
  int          v_cyc  [16];
  logic [15:0] v_out  [16];
  int          rd_n, v_n;

  initial begin
    reset = 1'b1; fifo_dout = '0; fifo_valid = 1'b0; fifo_empty = 1'b1;
    flush = 1'b0; req = 1'b0; auto_fifo = 1'b1; rd_pend = 1'b0;
`ifdef RANDOM_SLICER_COMPARE_EN
    threshold = 16'h8000;
`endif
    step(); step();
    chk("rst_rnd_out", 64'(rnd_out), 64'h0);
    chk("rst_rnd_valid", 64'(rnd_valid), 64'h0);
    chk("rst_rnd_ready", 64'(rnd_ready), 64'h0);
    chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
`ifdef RANDOM_SLICER_COMPARE_EN
    chk("rst_decision", 64'(decision), 64'h0);
`endif
    reset = 1'b0;
    step();

    // Single word, four back-to-back requests, LSB slice first.
    q.push_back(64'h0123_4567_89AB_CDEF); fifo_empty = 1'b0;
    step();
    chk("w1_rd_en", 64'(fifo_rd_en), 64'h1);
    chk("w1_ready_early", 64'(rnd_ready), 64'h0);
    step();
    chk("w1_rd_en_pulse", 64'(fifo_rd_en), 64'h0);
    step();
    chk("w1_ready", 64'(rnd_ready), 64'h1);
    req = 1'b1;
    exp_a = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    for (int i = 0; i < 4; i++) begin
      step();
      chk("w1_valid", 64'(rnd_valid), 64'h1);
      chk("w1_slice", 64'(rnd_out), 64'(exp_a[i]));
    end
    chk("w1_ready_done", 64'(rnd_ready), 64'h0);
    req = 1'b0;
    step();
    chk("w1_valid_off", 64'(rnd_valid), 64'h0);
    chk("w1_out_hold", 64'(rnd_out), 64'h0123);
    chk("w1_no_fetch", 64'(fifo_rd_en), 64'h0);

    // Flush together with req after one slice: flush wins, next word restarts at slice 0.
    q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
    q.push_back(64'h5555_6666_7777_8888);
    fifo_empty = 1'b0;
    step(); step(); step();
    chk("fl_ready", 64'(rnd_ready), 64'h1);
    req = 1'b1;
    step();
    chk("fl_first_slice", 64'(rnd_out), 64'hDDDD);
    flush = 1'b1;
    step();
    chk("fl_no_valid", 64'(rnd_valid), 64'h0);
    chk("fl_out_hold", 64'(rnd_out), 64'hDDDD);
    chk("fl_no_overrun", 64'(overrun), 64'h0);
    chk("fl_ready_clr", 64'(rnd_ready), 64'h0);
    flush = 1'b0; req = 1'b0;
    step();
    chk("fl_refetch", 64'(fifo_rd_en), 64'h1);
    step(); step();
    chk("fl_ready2", 64'(rnd_ready), 64'h1);
    req = 1'b1;
    step();
    chk("fl_next_slice0", 64'(rnd_out), 64'h8888);
    req = 1'b0;

    // Request with nothing available: ignored, sticky overrun, no fetch from an empty FIFO.
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("ov_ready0", 64'(rnd_ready), 64'h0);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("ov_no_valid", 64'(rnd_valid), 64'h0);
    chk("ov_set", 64'(overrun), 64'h1);
    rd_n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (fifo_rd_en) rd_n++;
    end
    chk("ov_sticky", 64'(overrun), 64'h1);
    chk("ov_no_rd_en", 64'(rd_n), 64'h0);

    // Two words, req held high: eight slices with one refill gap.
    q.push_back(64'h0001_0002_0003_0004);
    q.push_back(64'h0005_0006_0007_0008);
    fifo_empty = 1'b0; req = 1'b1;
    rd_n = 0; v_n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (fifo_rd_en && rd_n < 4) begin rd_cyc[rd_n] = i; rd_n++; end
      if (rnd_valid && v_n < 16) begin v_cyc[v_n] = i; v_out[v_n] = rnd_out; v_n++; end
    end
    req = 1'b0;
    chk("bb_rd_count", 64'(rd_n), 64'd2);
    chk("bb_valid_count", 64'(v_n), 64'd8);
    exp_b  = '{16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0008, 16'h0007, 16'h0006, 16'h0005};
    exp_vc = '{4, 5, 6, 7, 11, 12, 13, 14};
    if (rd_n == 2) begin
      chk("bb_rd0_cyc", 64'(rd_cyc[0]), 64'd1);
      chk("bb_rd1_cyc", 64'(rd_cyc[1]), 64'd8);
    end
    if (v_n == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("bb_slice", 64'(v_out[i]), 64'(exp_b[i]));
        chk("bb_valid_cyc", 64'(v_cyc[i]), 64'(exp_vc[i]));
      end
    end

    // Async reset while waiting on a read; the late response must be dropped.
    auto_fifo = 1'b0; fifo_empty = 1'b0;
    step();
    chk("ar_rd_en", 64'(fifo_rd_en), 64'h1);
    fifo_empty = 1'b1;
    step();
    #2 reset = 1'b1;
    #1;
    chk("ar_overrun0", 64'(overrun), 64'h0);
    chk("ar_out0", 64'(rnd_out), 64'h0);
    chk("ar_valid0", 64'(rnd_valid), 64'h0);
    chk("ar_ready0", 64'(rnd_ready), 64'h0);
    chk("ar_rd_en0", 64'(fifo_rd_en), 64'h0);
    step();
    reset = 1'b0;
    fifo_valid = 1'b1; fifo_dout = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    fifo_valid = 1'b0;
    chk("ar_late_ignored", 64'(rnd_ready), 64'h0);
    step();
    chk("ar_ready_stays0", 64'(rnd_ready), 64'h0);
    chk("ar_no_fetch", 64'(fifo_rd_en), 64'h0);
    auto_fifo = 1'b1; rd_pend = 1'b0;
    q.push_back(64'h0F0F_1E1E_2D2D_3C3C); fifo_empty = 1'b0;
    step();
    chk("ar_new_fetch", 64'(fifo_rd_en), 64'h1);
    step(); step();
    chk("ar_new_ready", 64'(rnd_ready), 64'h1);
    req = 1'b1;
    step();
    req = 1'b0;
    chk("ar_new_slice", 64'(rnd_out), 64'h3C3C);

`ifdef RANDOM_SLICER_COMPARE_EN
    // Threshold compare on slices 7FFF, 8000, FFFF.
    flush = 1'b1;
    step();
    flush = 1'b0;
    threshold = 16'h8000;
    q.push_back(64'h0000_FFFF_8000_7FFF); fifo_empty = 1'b0;
    step(); step(); step();
    chk("cmp_ready", 64'(rnd_ready), 64'h1);
    req = 1'b1;
    step();
    chk("cmp_s0", 64'(rnd_out), 64'h7FFF);
    chk("cmp_d0", 64'({rnd_valid, decision}), 64'b11);
    step();
    chk("cmp_s1", 64'(rnd_out), 64'h8000);
    chk("cmp_d1", 64'({rnd_valid, decision}), 64'b10);
    step();
    req = 1'b0;
    chk("cmp_s2", 64'(rnd_out), 64'hFFFF);
    chk("cmp_d2", 64'({rnd_valid, decision}), 64'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/random_slicer.md
RANDOM_SLICER -- requirements
Module: random_slicer

Interface
REQ-001 Parameter: SLICE_W, default 16, width in bits of each random value handed to the consumer.
REQ-002 Port: clk  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: fifo_dout  input  64  random word from the upstream random FIFO.
REQ-005 Port: fifo_valid  input  1  fifo_dout is valid this cycle; this is the response to a prior fifo_rd_en.
REQ-006 Port: fifo_empty  input  1  upstream FIFO holds no words.
REQ-007 Port: fifo_rd_en  output  1  one-cycle read acknowledge to the upstream FIFO.
REQ-008 Port: flush  input  1  discard the buffered word, e.g. after a new seed.
REQ-009 Port: req  input  1  consumer requests one slice.
REQ-010 Port: rnd_ready  output  1  a slice is available; req is accepted only while this is high.
REQ-011 Port: rnd_out  output  SLICE_W  random slice.
REQ-012 Port: rnd_valid  output  1  rnd_out is valid; one-cycle pulse.
REQ-013 Port: overrun  output  1  sticky flag: req was seen while rnd_ready was low.

Function
REQ-014 SLICE_W SHALL be 8, 16, 32 or 64; N = 64/SLICE_W.
REQ-015 The FSM SHALL have three states: IDLE, FETCH and WAIT.
REQ-016 IDLE to FETCH SHALL occur when slices_left==0, fifo_empty==0 and flush==0.
REQ-017 fifo_rd_en SHALL be high exactly in the FETCH cycle, then the FSM SHALL move to WAIT.
REQ-018 In WAIT, when fifo_valid==1, the block SHALL load fifo_dout into the 64-bit buffer, set slices_left=N and return to IDLE.
REQ-019 In IDLE or FETCH, fifo_valid SHALL be ignored.
REQ-020 rnd_ready SHALL equal (slices_left!=0), registered.
REQ-021 A req in cycle t with rnd_ready==1 SHALL produce rnd_valid=1 at t+1, with rnd_out equal to buffer[SLICE_W-1:0] as sampled at t.
REQ-022 On that same accepted req, the buffer SHALL shift right by SLICE_W and slices_left SHALL decrement.
REQ-023 Slices SHALL be issued LSB-first; N accepted reqs SHALL consume exactly one word.
REQ-024 Back-to-back reqs SHALL be accepted every cycle while rnd_ready==1.
REQ-025 req with rnd_ready==0 SHALL be ignored and SHALL set overrun; overrun SHALL clear only on reset.
REQ-026 flush SHALL set slices_left=0 and FSM=IDLE next cycle, and SHALL drop any pending WAIT.
REQ-027 flush SHALL win over a simultaneous req: no rnd_valid and no overrun.
REQ-028 rnd_out SHALL hold its last value while rnd_valid==0.
REQ-029 Refill latency: from the cycle slices_left becomes 0 (FIFO non-empty, 1-cycle FIFO read latency), fifo_rd_en SHALL assert one cycle later, and rnd_ready SHALL assert the cycle after fifo_valid.

Reset
REQ-030 On reset, the FSM SHALL be IDLE.
REQ-031 On reset, slices_left SHALL be 0, buffer 0, rnd_out 0, and rnd_valid, rnd_ready, fifo_rd_en and overrun SHALL all be 0.
REQ-032 A fifo_valid arriving after reset with no outstanding FETCH SHALL be discarded.

Configuration
REQ-033 With macro RANDOM_SLICER_COMPARE_EN defined, the block SHALL add input threshold[SLICE_W-1:0] and output decision.
REQ-034 decision SHALL be registered, aligned with rnd_valid, and equal to (slice < threshold), unsigned.
REQ-035 decision SHALL reset to 0.
REQ-036 Without RANDOM_SLICER_COMPARE_EN, neither threshold nor decision SHALL exist, and behaviour SHALL otherwise be identical.

Structure
REQ-037 Package random_pkg SHALL hold the FSM state typedef, the constant RANDOM_WORD_W=64, and the function computing N from SLICE_W.
REQ-038 The comparator SHALL be sub-module random_threshold_cmp, instantiated only under RANDOM_SLICER_COMPARE_EN; no other sub-modules.

Verification
REQ-039 SLICE_W=16; FIFO word 64'h0123_4567_89AB_CDEF; 4 consecutive reqs -> rnd_out CDEF, 89AB, 4567, 0123 on consecutive cycles, then rnd_ready=0.
REQ-040 FIFO empty; req pulse -> no rnd_valid, overrun=1 and stays 1; fifo_rd_en never asserts.
REQ-041 Two words queued; 8 reqs held high -> exactly two fifo_rd_en pulses, 8 rnd_valid pulses, and a refill gap matching REQ-029.
REQ-042 After 1 of 4 slices consumed, flush asserted together with req -> no rnd_valid; the next word is fetched and its slice 0 is issued first.
REQ-043 Reset asserted asynchronously while in WAIT -> all outputs 0 immediately; a late fifo_valid is ignored and rnd_ready stays 0 until a new fetch.
REQ-044 COMPARE_EN, threshold=16'h8000; slices 7FFF, 8000, FFFF -> decision 1, 0, 0, aligned with rnd_valid.
